// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAP,
    STOPPED
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  typedef struct packed {
    bcd_t sec_tens;
    bcd_t sec_units;
    bcd_t tenths;
    bcd_t hundredths;
  } sw_time_t;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// Single decade counter 0..MAX; carry flags the increment that wraps it to 0.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  assign carry = inc & (q == MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == MAX) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping: 100 Hz prescaler, BCD SS.hh count, start/stop, lap freeze and clear.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_lap,
  input  logic       key_clear,
  output logic [3:0] stopwatchsech,
  output logic [3:0] stopwatchsecl,
  output logic [3:0] stopwatchmsech,
  output logic [3:0] stopwatchmsecl,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  sw_time_t      live;
  sw_time_t      snap;
  sw_time_t      shown;

  logic key_start_d, key_lap_d, key_clear_d;
  logic start_edge, lap_edge, clear_edge;
  logic counting, tick, do_clear;
  logic carry_h, carry_t, carry_u, carry_s;

  // Previous-sample registers load even during reset, so a held key yields no edge.
  always_ff @(posedge clk) begin
    key_start_d <= key_start;
    key_lap_d   <= key_lap;
    key_clear_d <= key_clear;
  end

  assign start_edge = key_start & ~key_start_d;
  assign lap_edge   = key_lap & ~key_lap_d;
  assign clear_edge = key_clear & ~key_clear_d;

  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (presc == PRESC_LAST);
  assign do_clear = (state == STOPPED) && clear_edge;

  bcd_digit #(.MAX(BCD_MAX)) u_hundredths (
    .clk(clk), .rst(rst), .clr(do_clear), .inc(tick),
    .q(live.hundredths), .carry(carry_h)
  );

  bcd_digit #(.MAX(BCD_MAX)) u_tenths (
    .clk(clk), .rst(rst), .clr(do_clear), .inc(carry_h),
    .q(live.tenths), .carry(carry_t)
  );

  bcd_digit #(.MAX(BCD_MAX)) u_sec_units (
    .clk(clk), .rst(rst), .clr(do_clear), .inc(carry_t),
    .q(live.sec_units), .carry(carry_u)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(do_clear), .inc(carry_u),
    .q(live.sec_tens), .carry(carry_s)
  );

  // Prescaler holds its phase while stopped; only a clear back to IDLE zeroes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      ovf   <= 1'b0;
    end else begin
      if (do_clear) begin
        presc <= '0;
      end else if (counting) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (do_clear) begin
        ovf <= 1'b0;
      end else if (carry_s) begin
        ovf <= 1'b1;
      end
    end
  end

  // Control FSM; edge priority is clear (STOPPED only), then start, then lap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      snap       <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state      <= RUN;
            running    <= 1'b1;
            lap_active <= 1'b0;
          end
        end
        RUN: begin
          if (start_edge) begin
            state      <= STOPPED;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (lap_edge) begin
            state      <= LAP;
            snap       <= live;
            running    <= 1'b1;
            lap_active <= 1'b1;
          end
        end
        LAP: begin
          if (start_edge) begin
            state      <= STOPPED;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (lap_edge) begin
            state      <= RUN;
            running    <= 1'b1;
            lap_active <= 1'b0;
          end
        end
        STOPPED: begin
          if (clear_edge) begin
            state      <= IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (start_edge) begin
            state      <= RUN;
            running    <= 1'b1;
            lap_active <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          running    <= 1'b0;
          lap_active <= 1'b0;
        end
      endcase
    end
  end

  assign shown          = lap_active ? snap : live;
  assign stopwatchsech  = shown.sec_tens;
  assign stopwatchsecl  = shown.sec_units;
  assign stopwatchmsech = shown.tenths;
  assign stopwatchmsecl = shown.hundredths;

endmodule
